// File: rtl/clk_div_ctrl.sv
// Purpose : programmable clock divider with run / step / graceful-stop control.
// Latency : control inputs act on the next clk edge; rise_tick aligns with system_clk going high;
//           step_done pulses one cycle after the final falling edge of a step burst.
// Backpressure: div_valid/div_ready handshake; div_ready drops while a new divide value waits for a phase boundary.
// Ports   : clk, rst_n (sync, active-low); start / stop / step_req + step_cnt control requests;
//           div_valid / div_val / div_ready divide-value handshake; system_clk, rise_tick, step_done,
//           busy, cur_div status outputs.
module clk_div_ctrl #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step_req,
  input  logic [15:0]      step_cnt,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ready,
  output logic             system_clk,
  output logic             rise_tick,
  output logic             step_done,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, STOPPING} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             rise_q, rise_d;
  logic             arm_q, arm_d;    // final step fall seen; step_done follows one cycle later
  logic             done_q, done_d;
  logic [15:0]      rem_q, rem_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             tog;
  logic             xfer;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sclk_d     = sclk_q;
    rise_d     = 1'b0;
    arm_d      = 1'b0;
    done_d     = arm_q;
    rem_d      = rem_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    cur_div_d  = cur_div_q;

    // >= rather than == so the counter can never run past cur_div and wrap.
    tog  = (state_q != IDLE) && (cnt_q >= cur_div_q);
    xfer = div_valid && !pend_vld_q;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (start) begin
          state_d = RUN;
        end else if (step_req) begin
          if (step_cnt != 16'd0) begin
            rem_d   = step_cnt;
            state_d = STEP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN, STEP: begin
        if (stop) begin
          cnt_d = '0;
          if (!sclk_q) begin
            state_d = IDLE;
          end else if (tog) begin
            // High phase ends on this very edge: no need to visit STOPPING.
            state_d = IDLE;
            sclk_d  = 1'b0;
          end else begin
            state_d = STOPPING;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else if (tog) begin
          cnt_d  = '0;
          sclk_d = !sclk_q;
          rise_d = !sclk_q;
          if (state_q == STEP && sclk_q) begin
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = IDLE;
              arm_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOPPING: begin
        // Only entered with system_clk high, so the next toggle is always a fall.
        if (tog) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Divide-value handshake: immediate in IDLE, otherwise deferred to a phase boundary.
    if (state_q == IDLE) begin
      if (xfer) cur_div_d = div_val;
    end else begin
      if (tog && pend_vld_q) begin
        cur_div_d  = pend_q;
        pend_vld_d = 1'b0;
      end
      if (xfer) begin
        pend_d     = div_val;
        pend_vld_d = 1'b1;
      end
      if (state_d == IDLE) begin
        if (xfer)            cur_div_d = div_val;
        else if (pend_vld_q) cur_div_d = pend_q;
        pend_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sclk_q     <= 1'b0;
      rise_q     <= 1'b0;
      arm_q      <= 1'b0;
      done_q     <= 1'b0;
      rem_q      <= 16'd0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      cur_div_q  <= CNT_W'(DEFAULT_DIV);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sclk_q     <= sclk_d;
      rise_q     <= rise_d;
      arm_q      <= arm_d;
      done_q     <= done_d;
      rem_q      <= rem_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      cur_div_q  <= cur_div_d;
    end
  end

  assign div_ready  = !pend_vld_q;
  assign system_clk = sclk_q;
  assign rise_tick  = rise_q;
  assign step_done  = done_q;
  assign busy       = (state_q != IDLE);
  assign cur_div    = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Purpose : self-checking bench for clk_div_ctrl (table vectors, directed corner sequences, random vs reference model).
// Latency : outputs compared 1 ns after every rising clk edge.
// Backpressure: bench drives div_valid freely; the model tracks div_ready itself.
module tb_clk_div_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, step_req, div_valid;
  logic [15:0]   step_cnt;
  logic [W-1:0]  div_val;
  logic          div_ready, system_clk, rise_tick, step_done, busy;
  logic [W-1:0]  cur_div;

  int vectors = 0;
  int miscompares = 0;

  clk_div_ctrl #(.CNT_W(W), .DEFAULT_DIV(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_req(step_req),
    .step_cnt(step_cnt), .div_valid(div_valid), .div_val(div_val), .div_ready(div_ready),
    .system_clk(system_clk), .rise_tick(rise_tick), .step_done(step_done), .busy(busy),
    .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: phase countdown ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_STOPPING = 3;
  int          m_mode;
  bit          m_clk, m_rise, m_done, m_arm, m_pend_has;
  logic [W-1:0] m_div, m_pend;
  longint      m_left;   // cycles left in the current level
  int          m_rem;    // periods left in a step burst

  task automatic model_step();
    bit xfer, expired, to_idle;
    if (!rst_n) begin
      m_mode = M_IDLE; m_clk = 0; m_rise = 0; m_done = 0; m_arm = 0;
      m_pend_has = 0; m_div = 100; m_left = 0; m_rem = 0;
      return;
    end
    m_done = m_arm; m_arm = 0; m_rise = 0;
    xfer = div_valid && !m_pend_has;
    if (m_mode == M_IDLE) begin
      if (xfer) m_div = div_val;
      if (start) begin
        m_mode = M_RUN; m_left = longint'(m_div) + 1;
      end else if (step_req) begin
        if (step_cnt != 0) begin
          m_mode = M_STEP; m_rem = int'(step_cnt); m_left = longint'(m_div) + 1;
        end else m_done = 1;
      end
    end else begin
      m_left--;
      expired = (m_left == 0);
      if (expired && m_pend_has) begin m_div = m_pend; m_pend_has = 0; end
      if (xfer) begin m_pend = div_val; m_pend_has = 1; end
      to_idle = 0;
      if (m_mode != M_STOPPING && stop) begin
        if (!m_clk) to_idle = 1;
        else if (expired) begin to_idle = 1; m_clk = 0; end
        else m_mode = M_STOPPING;
      end else if (expired) begin
        m_clk = !m_clk; m_rise = m_clk; m_left = longint'(m_div) + 1;
        if (m_mode == M_STOPPING) to_idle = 1;
        else if (m_mode == M_STEP && !m_clk) begin
          m_rem--;
          if (m_rem == 0) begin to_idle = 1; m_arm = 1; end
        end
      end
      if (to_idle) begin
        m_mode = M_IDLE; m_clk = 0;
        if (m_pend_has) m_div = m_pend;
        m_pend_has = 0;
      end
    end
  endtask

  function automatic logic [63:0] pack(logic b, logic s, logic r, logic d, logic rdy, logic [W-1:0] c);
    return {27'd0, b, s, r, d, rdy, c};
  endfunction

  function automatic logic [63:0] dut_pack();
    return pack(busy, system_clk, rise_tick, step_done, div_ready, cur_div);
  endfunction

  function automatic logic [63:0] model_pack();
    return pack(m_mode != M_IDLE, m_clk, m_rise, m_done, !m_pend_has, m_div);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", dut_pack(), model_pack());
  endtask

  task automatic idle_inputs();
    rst_n = 1; start = 0; stop = 0; step_req = 0; step_cnt = 0; div_valid = 0; div_val = 0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic rst_n, start, stop, step_req;
    logic [15:0] step_cnt;
    logic div_valid;
    logic [W-1:0] div_val;
    logic busy, sclk, rise, done, ready;
    logic [W-1:0] cur;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic r, logic st, logic sp, logic sr, logic [15:0] sc, logic dv, logic [W-1:0] dval,
                     logic b, logic s, logic ri, logic d, logic rdy, logic [W-1:0] c, int n = 1);
    vec_t v;
    v = '{r, st, sp, sr, sc, dv, dval, b, s, ri, d, rdy, c};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    int rises, falls, t, t3, td;
    bit  prev_s, saw_done, done_ok;
    int  hi_len, lo_len;

    idle_inputs();
    rst_n = 0;

    // div=3 run, graceful stop, zero-length step, start+step collision
    add(0,0,0,0,0,0,0,   0,0,0,0,1,100);
    add(1,0,0,0,0,1,3,   0,0,0,0,1,3);
    add(1,1,0,0,0,0,0,   1,0,0,0,1,3);
    add(1,0,0,0,0,0,0,   1,0,0,0,1,3, 3);
    add(1,0,0,0,0,0,0,   1,1,1,0,1,3);
    add(1,0,0,0,0,0,0,   1,1,0,0,1,3, 3);
    add(1,0,0,0,0,0,0,   1,0,0,0,1,3, 4);
    add(1,0,0,0,0,0,0,   1,1,1,0,1,3);
    add(1,0,1,0,0,0,0,   1,1,0,0,1,3);
    add(1,0,0,0,0,0,0,   1,1,0,0,1,3, 2);
    add(1,0,0,0,0,0,0,   0,0,0,0,1,3);
    add(1,0,0,1,0,0,0,   0,0,0,1,1,3);
    add(1,1,0,1,2,0,0,   1,0,0,0,1,3);
    add(1,0,1,0,0,0,0,   0,0,0,0,1,3);
    add(1,0,0,0,0,0,0,   0,0,0,0,1,3);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; start = tbl[i].start; stop = tbl[i].stop;
      step_req = tbl[i].step_req; step_cnt = tbl[i].step_cnt;
      div_valid = tbl[i].div_valid; div_val = tbl[i].div_val;
      tick();
      chk($sformatf("tbl[%0d]", i), dut_pack(),
          pack(tbl[i].busy, tbl[i].sclk, tbl[i].rise, tbl[i].done, tbl[i].ready, tbl[i].cur));
    end
    idle_inputs();

    // ---- step burst: div=1, 3 periods ----
    div_valid = 1; div_val = 1; tick(); div_valid = 0;
    step_req = 1; step_cnt = 3; tick(); step_req = 0; step_cnt = 0;
    rises = 0; falls = 0; t3 = -1; td = -1; prev_s = system_clk; done_ok = 0;
    for (t = 0; t < 60 && td < 0; t++) begin
      tick();
      if (rise_tick) rises++;
      if (prev_s && !system_clk) begin falls++; if (falls == 3) t3 = t; end
      if (step_done) begin td = t; done_ok = !system_clk && !busy; end
      prev_s = system_clk;
    end
    chk("step_rises", 64'(rises), 64'd3);
    chk("step_done_lat", 64'(td - t3), 64'd1);
    chk("step_done_idle", 64'(done_ok), 64'd1);
    tick();
    chk("step_done_width", 64'(step_done), 64'd0);

    // ---- divide change during high phase: 3 -> 5 ----
    div_valid = 1; div_val = 3; tick(); div_valid = 0;
    start = 1; tick(); start = 0;
    for (t = 0; t < 20 && !rise_tick; t++) tick();
    chk("run_rise_seen", 64'(rise_tick), 64'd1);
    div_valid = 1; div_val = 5; tick(); div_valid = 0;
    chk("pend_ready_low", 64'(div_ready), 64'd0);
    hi_len = 2;
    for (t = 0; t < 20; t++) begin
      tick();
      if (!system_clk) break;
      hi_len++;
      chk("pend_ready_hold", 64'(div_ready), 64'd0);
    end
    chk("hi_len_old_div", 64'(hi_len), 64'd4);
    chk("ready_after_tog", 64'(div_ready), 64'd1);
    chk("cur_div_new", 64'(cur_div), 64'd5);
    lo_len = 1;
    for (t = 0; t < 20; t++) begin
      tick();
      if (system_clk) break;
      lo_len++;
    end
    chk("lo_len_new_div", 64'(lo_len), 64'd6);
    stop = 1; tick(); stop = 0;
    for (t = 0; t < 20 && busy; t++) tick();
    chk("stop_to_idle", 64'(busy), 64'd0);

    // ---- reset mid-step with div=7 ----
    div_valid = 1; div_val = 7; tick(); div_valid = 0;
    step_req = 1; step_cnt = 2; tick(); step_req = 0; step_cnt = 0;
    repeat (10) tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("reset_mid_step", dut_pack(), pack(0, 0, 0, 0, 1, 100));
    saw_done = 0;
    repeat (40) begin tick(); if (step_done) saw_done = 1; end
    chk("no_done_after_reset", 64'(saw_done), 64'd0);

    // ---- random traffic vs model ----
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 29) == 0);
      step_req  = ($urandom_range(0, 19) == 0);
      step_cnt  = 16'($urandom_range(0, 3));
      div_valid = ($urandom_range(0, 3) == 0);
      div_val   = W'($urandom_range(0, 4));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of the divide value and the phase counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 100, meaning the divide value loaded at reset; each half-period lasts div+1 clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to run continuously.
REQ-006 SHALL have port stop, input, 1 bit: one-cycle request for a graceful stop.
REQ-007 SHALL have port step_req, input, 1 bit: one-cycle request to run step_cnt full periods.
REQ-008 SHALL have port step_cnt, input, 16 bits: number of periods, sampled with step_req.
REQ-009 SHALL have port div_valid, input, 1 bit: a new divide value is offered.
REQ-010 SHALL have port div_val, input, CNT_W bits: the offered divide value.
REQ-011 SHALL have port div_ready, output, 1 bit: the block can accept a divide value.
REQ-012 SHALL have port system_clk, output, 1 bit: the divided clock, registered.
REQ-013 SHALL have port rise_tick, output, 1 bit: one-cycle pulse in the same cycle system_clk first reads 1.
REQ-014 SHALL have port step_done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 SHALL have port cur_div, output, CNT_W bits: the divide value currently in effect.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, STEP and STOPPING.
REQ-018 IDLE SHALL hold system_clk=0 and counter=0.
REQ-019 In IDLE, start SHALL go to RUN.
REQ-020 In IDLE, step_req with step_cnt!=0 SHALL load remaining=step_cnt and go to STEP.
REQ-021 In IDLE, step_req with step_cnt==0 SHALL pulse step_done on the next cycle and stay in IDLE.
REQ-022 When start and step_req arrive in the same cycle, start SHALL win.
REQ-023 In RUN, STEP and STOPPING, the counter SHALL increment every cycle; when counter==cur_div, system_clk SHALL toggle and the counter SHALL clear to 0 in the same edge.
REQ-024 The first edge after leaving IDLE SHALL be a rising edge after a full low phase of cur_div+1 cycles; no runt phase is permitted.
REQ-025 In RUN, stop SHALL go to STOPPING if system_clk=1, or to IDLE with the counter cleared if system_clk=0.
REQ-026 In STOPPING, the next falling toggle SHALL go to IDLE, with system_clk=0.
REQ-027 In STEP, each falling toggle SHALL decrement remaining; the falling toggle that makes remaining 0 SHALL go to IDLE and pulse step_done one cycle later.
REQ-028 In STEP, stop SHALL behave as in RUN (REQ-025), and no step_done SHALL be emitted.
REQ-029 start and step_req SHALL be ignored outside IDLE.
REQ-030 div_ready SHALL equal NOT pending_valid; a transfer occurs on div_valid && div_ready.
REQ-031 A transfer in IDLE SHALL update cur_div on the next cycle.
REQ-032 A transfer outside IDLE SHALL be held as pending and applied on the next toggle cycle (counter clear), so each phase uses one divide value.
REQ-033 The pending value SHALL be applied on entry to IDLE if still outstanding.
REQ-034 div_val=0 SHALL be legal and produce system_clk = clk/2.
REQ-035 The counter SHALL be CNT_W bits and never wrap, because the compare uses >= cur_div as a guard.

Reset
REQ-036 When rst_n=0 at a clk edge, the block SHALL set state=IDLE, counter=0, system_clk=0, rise_tick=0, step_done=0, busy=0, remaining=0, pending cleared, div_ready=1 and cur_div=DEFAULT_DIV.
REQ-037 Reset SHALL override all other inputs in the same cycle, including mid-STEP or STOPPING.

Verification
REQ-038 div=3 then start -> busy=1 next cycle; first rise 4 cycles after RUN entry; period 8 clk; rise_tick exactly 1 cycle wide.
REQ-039 div=1, step_req with step_cnt=3 -> exactly 3 rise_ticks; step_done 1 cycle after the 3rd falling edge; system_clk=0 and busy=0 after.
REQ-040 RUN at div=3; write div=5 during the high phase -> div_ready low until the toggle; the high phase is still 4 cycles; the next low phase is 6 cycles; cur_div=5.
REQ-041 stop asserted 1 cycle into the high phase at div=3 -> the high phase completes (4 cycles), then IDLE; no further rise_tick.
REQ-042 rst_n low 1 cycle mid-STEP with div=7 written -> next cycle all outputs at reset values, cur_div=100, no step_done.
REQ-043 step_cnt=0 -> step_done pulse, zero rise_ticks, busy stays 0; start+step_req together -> RUN entered, no step_done.
